// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register outstanding-write counters that raise
// a decode hazard stall on RAW use or counter saturation.
module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int W_RN  = 5,
  parameter int W_CNT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_v_i,
  input  logic [W_RN-1:0]   id_rd_num_i,
  input  logic [W_RN-1:0]   id_rs_num_i,
  input  logic              id_rd_used_i,
  input  logic              id_rs_used_i,
  input  logic              id_reserve_i,
  input  logic              ex_stall_i,
  input  logic              wb_v_i,
  input  logic [W_RN-1:0]   wb_rd_num_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [NREG-1:0]   busy_o,
  output logic              err_o,
  output logic [15:0]       stall_cnt_o
);

  localparam logic [W_CNT-1:0] CMAX    = {W_CNT{1'b1}};
  localparam logic [W_CNT-1:0] CNT_ONE = W_CNT'(1);

  logic [W_CNT-1:0] cnt_s [NREG];
  logic [NREG-1:0]  busy_s;
  logic             raw_s;
  logic             full_s;
  logic             stall_s;
  logic             reserve_s;
  logic             err_r;
  logic [15:0]      stall_cnt_r;

  // Hazard detection from current counters only; writebacks are not bypassed.
  always_comb begin
    raw_s     = (id_rs_used_i & busy_s[id_rs_num_i]) |
                (id_rd_used_i & busy_s[id_rd_num_i]);
    full_s    = id_reserve_i & (cnt_s[id_rd_num_i] == CMAX);
    stall_s   = id_v_i & (raw_s | full_s);
    reserve_s = id_v_i & ~stall_s & ~ex_stall_i & id_reserve_i;
  end

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    logic [W_CNT-1:0] cnt_r;
    logic             inc_s;
    logic             dec_s;

    assign inc_s     = reserve_s & (id_rd_num_i == W_RN'(g));
    assign dec_s     = wb_v_i & (wb_rd_num_i == W_RN'(g));
    assign cnt_s[g]  = cnt_r;
    assign busy_s[g] = |cnt_r;

    // Outstanding-write counter; a same-cycle reserve and release cancel out.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_r <= {W_CNT{1'b0}};
      end else if (flush_i) begin
        cnt_r <= {W_CNT{1'b0}};
      end else if (inc_s && !dec_s) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else if (dec_s && !inc_s && (cnt_r != {W_CNT{1'b0}})) begin
        cnt_r <= cnt_r - CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Sticky underflow flag: a release with nothing outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 1'b0;
    end else if (!flush_i && wb_v_i && (cnt_s[wb_rd_num_i] == {W_CNT{1'b0}})) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  // Saturating count of hazard-stall cycles (downstream stalls excluded).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 16'h0000;
    end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_o     = stall_s;
  assign busy_o      = busy_s;
  assign err_o       = err_r;
  assign stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: each vector queues its expected outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic        id_v_i;
  logic [4:0]  id_rd_num_i;
  logic [4:0]  id_rs_num_i;
  logic        id_rd_used_i;
  logic        id_rs_used_i;
  logic        id_reserve_i;
  logic        ex_stall_i;
  logic        wb_v_i;
  logic [4:0]  wb_rd_num_i;
  logic        flush_i;
  logic        stall_o;
  logic [31:0] busy_o;
  logic        err_o;
  logic [15:0] stall_cnt_o;

  typedef struct {
    string       nm;
    logic        stall;
    logic [31:0] busy;
    logic        err;
    logic [15:0] scnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors  = 0;
  int   failures = 0;

  reg_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .id_v_i       (id_v_i),
    .id_rd_num_i  (id_rd_num_i),
    .id_rs_num_i  (id_rs_num_i),
    .id_rd_used_i (id_rd_used_i),
    .id_rs_used_i (id_rs_used_i),
    .id_reserve_i (id_reserve_i),
    .ex_stall_i   (ex_stall_i),
    .wb_v_i       (wb_v_i),
    .wb_rd_num_i  (wb_rd_num_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs (at posedge+1), queue the outputs expected
  // before the next edge, then advance to the next posedge+1.
  task automatic vec(input string nm, input logic v, input logic [4:0] rd,
                     input logic [4:0] rs, input logic rdu, input logic rsu,
                     input logic res, input logic exs, input logic wbv,
                     input logic [4:0] wbr, input logic fl, input logic e_st,
                     input logic [31:0] e_busy, input logic e_err,
                     input logic [15:0] e_sc);
    exp_t e;
    id_v_i = v; id_rd_num_i = rd; id_rs_num_i = rs;
    id_rd_used_i = rdu; id_rs_used_i = rsu; id_reserve_i = res;
    ex_stall_i = exs; wb_v_i = wbv; wb_rd_num_i = wbr; flush_i = fl;
    e.nm = nm; e.stall = e_st; e.busy = e_busy; e.err = e_err; e.scnt = e_sc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (stall_o !== e.stall || busy_o !== e.busy || err_o !== e.err ||
          stall_cnt_o !== e.scnt) begin
        failures++;
        $display("FAIL %s: got stall=%0b busy=%h err=%0b scnt=%0d, want stall=%0b busy=%h err=%0b scnt=%0d",
                 e.nm, stall_o, busy_o, err_o, stall_cnt_o,
                 e.stall, e.busy, e.err, e.scnt);
      end
    end
  end

  initial begin
    rst = 1'b0;
    id_v_i = 1'b0; id_rd_num_i = 5'd0; id_rs_num_i = 5'd0;
    id_rd_used_i = 1'b0; id_rs_used_i = 1'b0; id_reserve_i = 1'b0;
    ex_stall_i = 1'b0; wb_v_i = 1'b0; wb_rd_num_i = 5'd0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    //            name          v     rd     rs     rdu   rsu   res   exs   wbv   wbr    fl    st    busy          err   scnt
    vec("reset",        1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0000, 1'b0, 16'd0);
    rst = 1'b1;
    // RAW on r3 held until the cycle after its writeback
    vec("raw_issue",    1'b1, 5'd3,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0000, 1'b0, 16'd0);
    vec("raw_st1",      1'b1, 5'd4,  5'd3,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 32'h0000_0008, 1'b0, 16'd0);
    vec("raw_st2",      1'b1, 5'd4,  5'd3,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 32'h0000_0008, 1'b0, 16'd1);
    vec("raw_wb_nobyp", 1'b1, 5'd4,  5'd3,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3,  1'b0, 1'b1, 32'h0000_0008, 1'b0, 16'd2);
    vec("raw_clear",    1'b1, 5'd4,  5'd3,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0000, 1'b0, 16'd3);
    vec("raw_r4_rel",   1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4,  1'b0, 1'b0, 32'h0000_0010, 1'b0, 16'd3);
    // immediate form does not see busy rs; rd_used does see busy rd
    vec("imm_res5",     1'b1, 5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0000, 1'b0, 16'd3);
    vec("imm_no_stall", 1'b1, 5'd6,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0020, 1'b0, 16'd3);
    vec("rd_used_st",   1'b1, 5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 32'h0000_0020, 1'b0, 16'd3);
    vec("imm_rel5",     1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 32'h0000_0020, 1'b0, 16'd4);
    // WAW saturation on r7
    vec("waw_res1",     1'b1, 5'd7,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0000, 1'b0, 16'd4);
    vec("waw_res2",     1'b1, 5'd7,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0080, 1'b0, 16'd4);
    vec("waw_res3",     1'b1, 5'd7,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0080, 1'b0, 16'd4);
    vec("waw_full",     1'b1, 5'd7,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 32'h0000_0080, 1'b0, 16'd4);
    vec("waw_full_wb",  1'b1, 5'd7,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7,  1'b0, 1'b1, 32'h0000_0080, 1'b0, 16'd5);
    vec("waw_resume",   1'b1, 5'd7,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0080, 1'b0, 16'd6);
    vec("waw_rel_a",    1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 32'h0000_0080, 1'b0, 16'd6);
    vec("waw_rel_b",    1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 32'h0000_0080, 1'b0, 16'd6);
    vec("waw_rel_c",    1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 32'h0000_0080, 1'b0, 16'd6);
    // downstream stall blocks the reserve and is not counted
    vec("exstall",      1'b1, 5'd8,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0000, 1'b0, 16'd6);
    vec("exstall_chk",  1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0000, 1'b0, 16'd6);
    // same-register reserve+release, then different registers
    vec("same_res2",    1'b1, 5'd2,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0000, 1'b0, 16'd6);
    vec("same_resrel2", 1'b1, 5'd2,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd2,  1'b0, 1'b0, 32'h0000_0004, 1'b0, 16'd6);
    vec("diff_res10",   1'b1, 5'd10, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd2,  1'b0, 1'b0, 32'h0000_0004, 1'b0, 16'd6);
    vec("diff_rel10",   1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0, 32'h0000_0400, 1'b0, 16'd6);
    // underflow on r9 sets a sticky error
    vec("uflow_rel9",   1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 1'b0, 32'h0000_0000, 1'b0, 16'd6);
    vec("uflow_sticky", 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0000, 1'b1, 16'd6);
    // flush with 0xF0 busy plus a concurrent reserve of r1
    vec("fl_res4",      1'b1, 5'd4,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0000, 1'b1, 16'd6);
    vec("fl_res5",      1'b1, 5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0010, 1'b1, 16'd6);
    vec("fl_res6",      1'b1, 5'd6,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0030, 1'b1, 16'd6);
    vec("fl_res7",      1'b1, 5'd7,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0070, 1'b1, 16'd6);
    vec("flush_res1",   1'b1, 5'd1,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 32'h0000_00F0, 1'b1, 16'd6);
    vec("flush_done",   1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0000, 1'b1, 16'd6);
    // flush leaves the flush-cycle stall intact
    vec("fst_res4",     1'b1, 5'd4,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0000, 1'b1, 16'd6);
    vec("fst_flush",    1'b1, 5'd0,  5'd4,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 32'h0000_0010, 1'b1, 16'd6);
    vec("fst_after",    1'b1, 5'd0,  5'd4,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0000, 1'b1, 16'd7);
    // async reset mid-stall, then release of the discarded reservation
    vec("rs_res3",      1'b1, 5'd3,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0000, 1'b1, 16'd7);
    vec("rs_stall",     1'b1, 5'd0,  5'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 32'h0000_0008, 1'b1, 16'd7);
    rst = 1'b0;
    vec("rs_async",     1'b1, 5'd0,  5'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0000, 1'b0, 16'd0);
    rst = 1'b1;
    vec("rs_rel3",      1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  1'b0, 1'b0, 32'h0000_0000, 1'b0, 16'd0);
    vec("rs_err",       1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000_0000, 1'b1, 16'd0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
    $finish;
  end

endmodule
